// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with the HI/LO register pair.
// One operand bit is processed per cycle; the pipeline is stalled until HI/LO are written.
module ex_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid_i,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hilo_rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CNT_W = $clog2(ITER);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             prod_sgn_q, prod_sgn_d;
    logic             rem_sgn_q, rem_sgn_d;

    function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    logic dec_r, dec_mul, dec_div, dec_signed, start;
    logic [31:0] rs_mag, rt_mag;

    assign dec_r      = op_valid_i && (opcode_i == 6'h00);
    assign dec_mul    = dec_r && (funct_i == F_MULT || funct_i == F_MULTU);
    assign dec_div    = dec_r && (funct_i == F_DIV  || funct_i == F_DIVU);
    assign dec_signed = (funct_i == F_MULT || funct_i == F_DIV);
    // Gated by reset so a held instruction cannot re-raise stall while reset is asserted.
    assign start      = !reset && (dec_mul || dec_div) && (state_q == IDLE);
    assign rs_mag     = cneg32(dec_signed && rs_data_i[31], rs_data_i);
    assign rt_mag     = cneg32(dec_signed && rt_data_i[31], rt_data_i);

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_nxt = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; restoring subtract on the shifted remainder.
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_new;
    logic [63:0] div_nxt, step_nxt, mul_res;
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign div_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_new  = div_ge ? 32'(rem_sh - {1'b0, opb_q}) : rem_sh[31:0];
    assign div_nxt  = {rem_new, acc_q[30:0], div_ge};
    assign step_nxt = is_div_q ? div_nxt : mul_nxt;
    assign mul_res  = cneg64(prod_sgn_q, step_nxt);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        prod_sgn_d = prod_sgn_q;
        rem_sgn_d  = rem_sgn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d   = dec_div;
                    prod_sgn_d = dec_signed && (rs_data_i[31] ^ rt_data_i[31]);
                    rem_sgn_d  = dec_signed && rs_data_i[31];
                    cnt_d      = '0;
                    acc_d      = {32'd0, dec_div ? rs_mag : rt_mag};
                    opb_d      = dec_div ? rt_mag : rs_mag;
                    if (dec_div && rt_data_i == 32'd0) begin
                        state_d = DONE;
                        hi_d    = rs_data_i;
                        lo_d    = 32'hFFFF_FFFF;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (dec_r && funct_i == F_MTHI) begin
                    hi_d = rs_data_i;
                end else if (dec_r && funct_i == F_MTLO) begin
                    lo_d = rs_data_i;
                end
            end
            BUSY: begin
                acc_d = step_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        lo_d = cneg32(prod_sgn_q, step_nxt[31:0]);
                        hi_d = cneg32(rem_sgn_q, step_nxt[63:32]);
                    end else begin
                        lo_d = mul_res[31:0];
                        hi_d = mul_res[63:32];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q      <= acc_d;
        opb_q      <= opb_d;
        is_div_q   <= is_div_d;
        prod_sgn_q <= prod_sgn_d;
        rem_sgn_q  <= rem_sgn_d;
    end

    assign stall_o      = start || (state_q == BUSY);
    assign busy_o       = (state_q != IDLE);
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign hilo_rdata_o = (dec_r && funct_i == F_MFHI) ? hi_q :
                          (dec_r && funct_i == F_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: products, quotients, divide-by-zero, HI/LO moves, reset abort.
module tb_ex_muldiv_unit;
    logic        clk;
    logic        reset;
    logic        op_valid_i;
    logic [5:0]  opcode_i;
    logic [5:0]  funct_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hilo_rdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;
    int n;

    ex_muldiv_unit #(.ITER(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid_i   (op_valid_i),
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .hilo_rdata_o (hilo_rdata_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents an instruction at a falling edge and returns in its first non-stalled cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        op_valid_i = 1'b1;
        opcode_i   = 6'h00;
        funct_i    = f;
        rs_data_i  = a;
        rt_data_i  = b;
        cyc        = 0;
        #1;
        while (stall_o && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bubble();
        @(negedge clk);
        op_valid_i = 1'b0;
        funct_i    = 6'h00;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        op_valid_i = 1'b0;
        opcode_i   = 6'h00;
        funct_i    = 6'h00;
        rs_data_i  = 32'd0;
        rt_data_i  = 32'd0;
        #2;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o},  32'd0);
        chk("rst_hi",    hi_o, 32'd0);
        chk("rst_lo",    lo_o, 32'd0);
        chk("rst_rdata", hilo_rdata_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_stall_cycles", n, 32'd33);
        chk("multu_done_busy", {31'd0, busy_o}, 32'd1);
        chk("multu_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", lo_o, 32'h0000_0001);
        bubble();
        chk("after_done_busy", {31'd0, busy_o}, 32'd0);

        run_op(6'h18, 32'hFFFF_FFFD, 32'd5, n);
        chk("mult_stall_cycles", n, 32'd33);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFF1);
        run_op(6'h12, 32'd0, 32'd0, n);
        chk("mflo_no_stall", n, 32'd0);
        chk("mflo_rdata", hilo_rdata_o, 32'hFFFF_FFF1);

        run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_stall_cycles", n, 32'd33);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);
        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 32'h0000_0000);

        run_op(6'h1B, 32'd100, 32'd0, n);
        chk("divz_stall_cycles", n, 32'd1);
        chk("divz_done_busy", {31'd0, busy_o}, 32'd1);
        chk("divz_hi", hi_o, 32'h0000_0064);
        chk("divz_lo", lo_o, 32'hFFFF_FFFF);

        run_op(6'h11, 32'h1234_5678, 32'd0, n);
        chk("mthi_no_stall", n, 32'd0);
        run_op(6'h10, 32'd0, 32'd0, n);
        chk("mfhi_no_stall", n, 32'd0);
        chk("mfhi_rdata", hilo_rdata_o, 32'h1234_5678);
        run_op(6'h13, 32'hCAFE_0001, 32'd0, n);
        run_op(6'h12, 32'd0, 32'd0, n);
        chk("mflo_after_mtlo", hilo_rdata_o, 32'hCAFE_0001);
        bubble();
        chk("bubble_rdata", hilo_rdata_o, 32'd0);

        @(negedge clk);
        op_valid_i = 1'b1;
        opcode_i   = 6'h00;
        funct_i    = 6'h19;
        rs_data_i  = 32'd7;
        rt_data_i  = 32'd9;
        repeat (10) @(negedge clk);
        #1;
        chk("busy10_stall", {31'd0, stall_o}, 32'd1);
        chk("busy10_busy",  {31'd0, busy_o},  32'd1);
        reset      = 1'b1;
        op_valid_i = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        chk("abort_busy",  {31'd0, busy_o},  32'd0);
        chk("abort_hi", hi_o, 32'd0);
        chk("abort_lo", lo_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(6'h19, 32'd7, 32'd9, n);
        chk("rerun_stall_cycles", n, 32'd33);
        chk("rerun_lo", lo_o, 32'd63);
        chk("rerun_hi", hi_o, 32'd0);
        bubble();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit with the HI/LO register pair, in the EX stage. It consumes the opcode, funct and operand fields registered by the ID/EX pipeline register. It runs MULT/MULTU/DIV/DIVU over multiple cycles and raises a stall that freezes PC, IF/ID and ID/EX until the result is written. It also serves MFHI/MFLO reads and MTHI/MTLO writes to the EX result path.

## Interface
Parameters:
- ITER, 32, iterations per multiply/divide (one operand bit per cycle); fixed at 32 for this design

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op_valid_i  in  1  EX holds a real instruction (0 for a bubble)
- opcode_i  in  6  instruction opcode from ID/EX
- funct_i  in  6  instruction funct from ID/EX
- rs_data_i  in  32  rs operand (after forwarding): multiplicand / dividend / MTxx source
- rt_data_i  in  32  rt operand: multiplier / divisor
- stall_o  out  1  freeze PC, IF/ID, ID/EX; ID/EX must hold its outputs while high
- busy_o  out  1  FSM not in IDLE
- hilo_rdata_o  out  32  HI for MFHI, LO for MFLO, else 0
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

## Operation
- Decode applies only when opcode_i = 6'h00 and op_valid_i = 1. Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- `start` = op_valid_i & (MULT|MULTU|DIV|DIVU) & state==IDLE.
- FSM states and transitions:
  - IDLE → BUSY on start, divisor ≠ 0 or multiply.
  - IDLE → DONE on start with DIV/DIVU and rt_data_i = 0.
  - BUSY → DONE after the 32nd iteration.
  - DONE → IDLE unconditionally.
- On start, latch:
  - operand magnitudes: two's-complement absolute value for signed ops, raw values for unsigned
  - result-sign flags: product/quotient sign = rs[31]^rt[31]; remainder sign = rs[31]; both 0 for unsigned
  - op type
  - iteration counter = 0
- Multiply: shift-add on the 64-bit accumulator, one multiplier bit per cycle. On the final iteration, negate the 64-bit result if the sign flag is set. HI = [63:32], LO = [31:0].
- Divide: restoring, one quotient bit per cycle. On the final iteration:
  - LO = quotient, negated if the quotient sign is set
  - HI = remainder, negated if the remainder sign is set
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0; no trap.
- Divide by zero: HI = rs_data_i, LO = 0xFFFFFFFF, written on the IDLE→DONE edge.
- MTHI/MTLO: write rs_data_i to HI/LO on the clock edge when decoded in IDLE. They have no stall.
- hilo_rdata_o is combinational from the HI/LO registers. The stall guarantees MFHI/MFLO never observe a pending result.
- Decoding is ignored while state ≠ IDLE. The pipeline is frozen, so inputs are stable.
- DONE never restarts, even though the same mul/div instruction is still present in EX.

## Timing
- Reset, asynchronous, immediate:
  - state = IDLE; HI = LO = 0; counter = 0
  - stall_o = 0, busy_o = 0, hilo_rdata_o = 0 (given a non-MFxx input)
- Reset during BUSY aborts the operation; HI/LO read 0 afterwards.
- stall_o = start | (state==BUSY). It is combinational, so it rises in the same cycle the instruction arrives in EX.
- Mul, or div with nonzero divisor:
  - cycle 0 = IDLE/start; cycles 1–32 = BUSY
  - HI/LO update on the edge ending cycle 32
  - cycle 33 = DONE: stall_o = 0, instruction leaves EX at the end of cycle 33
  - stall_o high for exactly 33 cycles
- Divide by zero: stall_o high for 1 cycle (cycle 0); DONE in cycle 1.
- MTHI/MTLO value is visible on hi_o/lo_o and hilo_rdata_o in the next cycle, so a back-to-back MFHI reads the new value.
- busy_o is high in BUSY and DONE.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; stall_o high 33 cycles, low in the DONE cycle.
- MULT rs=0xFFFFFFFD (−3), rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; then MFLO → hilo_rdata_o=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 → HI=0x64, LO=0xFFFFFFFF; stall_o high exactly 1 cycle.
- MTHI rs=0x12345678, then MFHI next cycle → hilo_rdata_o=0x12345678, no stall.
- MULTU 7×9 with reset asserted in BUSY cycle 10 → stall_o, busy_o drop immediately; HI=LO=0. The next MULTU 7×9 gives LO=63, HI=0.
